score_glyph_encoder: RTL and testbench
======================================

// Module: score_glyph_encoder
// PURPOSE
//  Encodes a binary game score into six 5-bit glyph codes (hex1..hex6) for the per-digit
//  7-segment decoders on the HUD. It is the producer side of the glyph-code interface.
//  Conversion is an iterative double-dabble (shift/add-3) engine with a load/busy/done handshake.
//  Displayed digits change atomically on commit, so they never flicker mid-conversion.
// PARAMETERS
//  SCORE_W    20      width of score_in; conversion takes SCORE_W shift cycles; legal range 20..24
//  MAX_SCORE  999999  largest displayable value; any larger value shows the overflow pattern
// PORTS
//  clk           in   1   system clock; all state updates on rising edge
//  resetN        in   1   asynchronous active-low reset
//  score_in      in   SCORE_W  binary score; sampled only on the edge where score_load=1
//  score_load    in   1   one-cycle request to convert score_in
//  busy          out  1   conversion in progress
//  digits_valid  out  1   one-cycle pulse: hex1..hex6 updated on this edge
//  hex1..hex6    out  5   glyph codes; hex1 = ones digit, hex6 = hundred-thousands (leftmost)
// BEHAVIOUR
//  - Reset (async, resetN=0) values: busy=0, digits_valid=0, pending=0, FSM=IDLE.
//    hex1..hex6 reset to GLYPH_0 (5'd0); the variant with LEAD_ZERO_BLANK_EN changes hex2..hex6.
//  - Glyph codes: 0..9 digits, 16 'P', 17 '-', 31 blank (segments off).
//  - FSM states: IDLE -> CONV -> COMMIT -> IDLE.
//    IDLE: on score_load, latch score_in into the shift register, clear the 24-bit BCD accumulator,
//      and set ovf = (score_in > MAX_SCORE). Go to CONV with cnt=0. busy=1 from the next edge.
//    CONV: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd,bin} left 1; cnt++.
//      After SCORE_W cycles, go to COMMIT.
//    COMMIT: register all six glyphs at once and pulse digits_valid=1 for one cycle.
//      If ovf, all six glyphs = 17 ('------').
//      If pending, relaunch from the pending value; busy stays 1 and the next state is CONV.
//      Otherwise busy=0 and the next state is IDLE.
//  - Latency: from the load edge to the digits_valid edge is exactly SCORE_W+1 cycles (21 by default).
//    This holds for every value, including overflow values.
//  - score_load while busy: capture score_in into the pending register and set pending=1.
//    A later load overwrites it (latest value wins). Never drop the newest value.
//  - score_load in the COMMIT cycle counts as pending and relaunches immediately, with no IDLE gap.
//  - Between commits, hex1..hex6 hold their last committed values.
//  - resetN asserted mid-conversion aborts the conversion: outputs return to reset values and pending is lost.
//  - Intermediate BCD uses 4*6=24 bits. Bits shifted beyond the sixth nibble are discarded;
//    such values are covered by ovf.
// CONFIGURATION
//  LEAD_ZERO_BLANK_EN defined:
//    at COMMIT, each leading zero digit from hex6 down to hex2 becomes GLYPH_BLANK (31).
//    hex1 is never blanked, so a score of 0 shows a single '0'.
//    At reset, hex2..hex6 = 31 and hex1 = 0. The overflow pattern is unaffected.
//  LEAD_ZERO_BLANK_EN undefined: all six digits are always shown, with zero padding.
// STRUCTURE
//  - Package glyph_pkg: typedef logic [4:0] glyph_t; GLYPH_0=5'd0, GLYPH_P=5'd16,
//    GLYPH_DASH=5'd17, GLYPH_BLANK=5'd31; enum typedef for the FSM states.
//    The per-digit 7-seg decoders share this package.
//  - Sub-module dd_digit_cell: combinational 4-bit add-3-if->=5 cell, instantiated 6x in a generate loop.
//  - Top module: FSM, cycle counter (width $clog2(SCORE_W+1)), shift registers, pending register,
//    and output registers.
// TESTING
//  1. Reset, then score_load with 123456 -> busy=1 for 21 cycles; digits_valid pulses on cycle 21;
//     hex6..hex1 = 1,2,3,4,5,6.
//  2. Load 0 -> hex1..hex6 = 0 (macro off); hex1=0, hex2..hex6=31 (macro on).
//  3. Load 999999 -> all 9s; then load 1000000 -> all six = 17, with the same 21-cycle latency.
//  4. Load 42; at cycle 5 load 77, at cycle 9 load 88 -> first commit shows 42; second commit
//     follows 21 cycles later and shows 88; 77 never appears.
//  5. Load 500 and drop resetN at cycle 10 -> outputs return to reset values immediately;
//     after release, no digits_valid pulse occurs.
//  6. Load 1000 with the macro on -> hex6,hex5 = 31; hex4..hex1 = 1,0,0,0. Inner zeros are not blanked.

Source files
------------

// File: rtl/score_glyph_encoder_pkg.sv
// Shared glyph definitions for the score encoder and the per-digit 7-segment decoders.
package glyph_pkg;

    typedef logic [4:0] glyph_t;

    localparam glyph_t GLYPH_0     = 5'd0;
    localparam glyph_t GLYPH_P     = 5'd16;
    localparam glyph_t GLYPH_DASH  = 5'd17;
    localparam glyph_t GLYPH_BLANK = 5'd31;

    localparam int BCD_DIGITS = 6;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } enc_state_t;

    function automatic glyph_t digit_glyph(input logic [3:0] nib);
        return {1'b0, nib};
    endfunction

endpackage

// File: rtl/score_glyph_encoder_if.sv
// Glyph-code interface between the score encoder (master) and the HUD digit decoders (slave).
interface score_glyph_encoder_if #(parameter int SCORE_W = 20);
    import glyph_pkg::*;

    logic [SCORE_W-1:0] score_in;
    logic               score_load;
    logic               busy;
    logic               digits_valid;
    glyph_t             hex1;
    glyph_t             hex2;
    glyph_t             hex3;
    glyph_t             hex4;
    glyph_t             hex5;
    glyph_t             hex6;

    modport master (
        input  score_in, score_load,
        output busy, digits_valid, hex1, hex2, hex3, hex4, hex5, hex6
    );

    modport slave (
        output score_in, score_load,
        input  busy, digits_valid, hex1, hex2, hex3, hex4, hex5, hex6
    );

endinterface

// File: rtl/score_glyph_encoder_dd_digit_cell.sv
// One BCD nibble of the double-dabble engine: add 3 when the digit is 5 or more.
module dd_digit_cell (
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Pre-shift correction so the following left shift carries into the next nibble.
    always_comb begin
        if (d >= 4'd5) begin
            q = d + 4'd3;
        end else begin
            q = d;
        end
    end

endmodule

// File: rtl/score_glyph_encoder.sv
// Binary score to six glyph codes via iterative double-dabble, committed atomically.
// Optional build macro LEAD_ZERO_BLANK_EN blanks leading zeros on hex6..hex2.
module score_glyph_encoder
    import glyph_pkg::*;
#(
    parameter int SCORE_W   = 20,
    parameter int MAX_SCORE = 999999
) (
    input logic                   clk,
    input logic                   resetN,
    score_glyph_encoder_if.master gif
);

    localparam int                 CNT_W = $clog2(SCORE_W + 1);
    localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(MAX_SCORE);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(SCORE_W - 1);

`ifdef LEAD_ZERO_BLANK_EN
    localparam glyph_t RST_HI = GLYPH_BLANK;
`else
    localparam glyph_t RST_HI = GLYPH_0;
`endif

    enc_state_t                 state_r;
    logic [CNT_W-1:0]           cnt_r;
    logic [SCORE_W-1:0]         bin_r;
    logic [BCD_W-1:0]           bcd_r;
    logic                       ovf_r;
    logic [SCORE_W-1:0]         pend_val_r;
    logic                       pend_r;
    logic                       busy_r;
    logic                       valid_r;
    glyph_t                     hex_r [BCD_DIGITS];

    logic [BCD_W-1:0]           bcd_adj_s;
    logic [BCD_W+SCORE_W-1:0]   shift_s;
    logic [SCORE_W-1:0]         next_val_s;
    glyph_t                     glyph_s [BCD_DIGITS];

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_cell
        dd_digit_cell u_cell (
            .d (bcd_r[4*g +: 4]),
            .q (bcd_adj_s[4*g +: 4])
        );
    end

    // The top bit of the shifted BCD falls off here; values that large are flagged by ovf.
    assign shift_s = {bcd_adj_s, bin_r} << 1;

    // A load on the relaunch edge is newer than anything already pending.
    always_comb begin
        if (gif.score_load) begin
            next_val_s = gif.score_in;
        end else begin
            next_val_s = pend_val_r;
        end
    end

`ifdef LEAD_ZERO_BLANK_EN
    // Glyphs to commit: dash pattern on overflow, otherwise digits with leading zeros blanked.
    always_comb begin
        logic lead;
        lead = 1'b1;
        for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
            if (ovf_r) begin
                glyph_s[i] = GLYPH_DASH;
            end else if (lead && (i != 0) && (bcd_r[4*i +: 4] == 4'd0)) begin
                glyph_s[i] = GLYPH_BLANK;
            end else begin
                glyph_s[i] = digit_glyph(bcd_r[4*i +: 4]);
                lead       = 1'b0;
            end
        end
    end
`else
    // Glyphs to commit: dash pattern on overflow, otherwise zero-padded digits.
    always_comb begin
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (ovf_r) begin
                glyph_s[i] = GLYPH_DASH;
            end else begin
                glyph_s[i] = digit_glyph(bcd_r[4*i +: 4]);
            end
        end
    end
`endif

    // Conversion FSM with pending-load capture and registered handshake/glyph outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            bin_r      <= '0;
            bcd_r      <= '0;
            ovf_r      <= 1'b0;
            pend_val_r <= '0;
            pend_r     <= 1'b0;
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            hex_r[0]   <= GLYPH_0;
            for (int i = 1; i < BCD_DIGITS; i++) begin
                hex_r[i] <= RST_HI;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    valid_r <= 1'b0;
                    pend_r  <= 1'b0;
                    if (gif.score_load) begin
                        bin_r   <= gif.score_in;
                        bcd_r   <= '0;
                        ovf_r   <= (gif.score_in > MAX_V);
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_CONV;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_CONV: begin
                    valid_r <= 1'b0;
                    bcd_r   <= shift_s[BCD_W+SCORE_W-1:SCORE_W];
                    bin_r   <= shift_s[SCORE_W-1:0];
                    cnt_r   <= cnt_r + 1'b1;
                    if (cnt_r == LAST_CNT) begin
                        state_r <= ST_COMMIT;
                    end else begin
                        state_r <= ST_CONV;
                    end
                    if (gif.score_load) begin
                        pend_val_r <= gif.score_in;
                        pend_r     <= 1'b1;
                    end else begin
                        pend_r     <= pend_r;
                    end
                end
                ST_COMMIT: begin
                    hex_r   <= glyph_s;
                    valid_r <= 1'b1;
                    pend_r  <= 1'b0;
                    if (gif.score_load || pend_r) begin
                        bin_r   <= next_val_s;
                        bcd_r   <= '0;
                        ovf_r   <= (next_val_s > MAX_V);
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_CONV;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                    pend_r  <= 1'b0;
                end
            endcase
        end
    end

    assign gif.busy         = busy_r;
    assign gif.digits_valid = valid_r;
    assign gif.hex1         = hex_r[0];
    assign gif.hex2         = hex_r[1];
    assign gif.hex3         = hex_r[2];
    assign gif.hex4         = hex_r[3];
    assign gif.hex5         = hex_r[4];
    assign gif.hex6         = hex_r[5];

endmodule

// File: tb/tb_score_glyph_encoder.sv
// Scoreboard bench for score_glyph_encoder: directed loads, expected glyphs queued, monitor compares.
module tb_score_glyph_encoder;
    import glyph_pkg::*;

    typedef struct {
        logic [29:0] hex;
        int          cyc;
        string       name;
    } exp_t;

    logic clk;
    logic resetN;
    int   cyc;
    int   checks;
    int   errors;
    exp_t exp_q [$];

    score_glyph_encoder_if #(.SCORE_W(20)) gif ();

    score_glyph_encoder #(.SCORE_W(20), .MAX_SCORE(999999)) dut (
        .clk    (clk),
        .resetN (resetN),
        .gif    (gif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [29:0] g6(input int d6, input int d5, input int d4,
                                       input int d3, input int d2, input int d1);
        return {5'(d6), 5'(d5), 5'(d4), 5'(d3), 5'(d2), 5'(d1)};
    endfunction

    function automatic logic [29:0] cur_hex();
        return {gif.hex6, gif.hex5, gif.hex4, gif.hex3, gif.hex2, gif.hex1};
    endfunction

`ifdef LEAD_ZERO_BLANK_EN
    localparam logic [29:0] EXP_RST  = {5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd0};
    localparam logic [29:0] EXP_0    = {5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd0};
    localparam logic [29:0] EXP_42   = {5'd31, 5'd31, 5'd31, 5'd31, 5'd4,  5'd2};
    localparam logic [29:0] EXP_88   = {5'd31, 5'd31, 5'd31, 5'd31, 5'd8,  5'd8};
    localparam logic [29:0] EXP_7    = {5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd7};
    localparam logic [29:0] EXP_1000 = {5'd31, 5'd31, 5'd1,  5'd0,  5'd0,  5'd0};
`else
    localparam logic [29:0] EXP_RST  = 30'd0;
    localparam logic [29:0] EXP_0    = 30'd0;
    localparam logic [29:0] EXP_42   = {5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd2};
    localparam logic [29:0] EXP_88   = {5'd0, 5'd0, 5'd0, 5'd0, 5'd8, 5'd8};
    localparam logic [29:0] EXP_7    = {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7};
    localparam logic [29:0] EXP_1000 = {5'd0, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0};
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int v);
        gif.score_in   = 20'(v);
        gif.score_load = 1'b1;
        step(1);
        gif.score_load = 1'b0;
    endtask

    task automatic push(input string name, input logic [29:0] h, input int c);
        exp_t e;
        e.name = name;
        e.hex  = h;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Waits for busy to drop; returns the number of cycles it stayed high after the load.
    task automatic wait_idle(output int n);
        n = 1;
        while (gif.busy === 1'b1 && n < 200) begin
            step(1);
            if (gif.busy === 1'b1) n++;
        end
        if (n >= 200) begin
            errors++;
            checks++;
            $display("FAIL busy_timeout: busy still high after %0d cycles, expected low", n);
        end
        step(1);
    endtask

    task automatic run_single(input string name, input int v, input logic [29:0] h);
        int k;
        int n;
        k = cyc;
        push(name, h, k + 22);
        pulse(v);
        check({name, "_busy_start"}, 32'(gif.busy), 32'd1);
        wait_idle(n);
        check({name, "_busy_len"}, 32'(n), 32'd21);
    endtask

    // Monitor: every digits_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetN === 1'b1 && gif.digits_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: digits_valid=1 with hex=%0h, expected no pulse (cycle %0d)",
                         cur_hex(), cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_hex"}, 32'(cur_hex()), 32'(e.hex));
                check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        int k;
        int n;
        cyc            = 0;
        checks         = 0;
        errors         = 0;
        resetN         = 1'b0;
        gif.score_in   = 20'd0;
        gif.score_load = 1'b0;
        step(3);
        check("reset_busy", 32'(gif.busy), 32'd0);
        check("reset_valid", 32'(gif.digits_valid), 32'd0);
        check("reset_hex", 32'(cur_hex()), 32'(EXP_RST));
        resetN = 1'b1;
        step(2);

        run_single("v123456", 123456, g6(1, 2, 3, 4, 5, 6));
        run_single("v0", 0, EXP_0);
        run_single("v999999", 999999, g6(9, 9, 9, 9, 9, 9));
        run_single("v1000000", 1000000, g6(17, 17, 17, 17, 17, 17));
        run_single("v1048575", 1048575, g6(17, 17, 17, 17, 17, 17));
        run_single("v1000", 1000, EXP_1000);
        check("hold_hex", 32'(cur_hex()), 32'(EXP_1000));

        // Two loads while busy: only the newest (88) relaunches after the 42 commit.
        k = cyc;
        push("v42", EXP_42, k + 22);
        push("v88", EXP_88, k + 43);
        pulse(42);
        step(4);
        pulse(77);
        step(3);
        pulse(88);
        wait_idle(n);

        // Load landing on the commit edge relaunches with no idle gap.
        k = cyc;
        push("v7", EXP_7, k + 22);
        push("v654321", g6(6, 5, 4, 3, 2, 1), k + 43);
        pulse(7);
        step(20);
        pulse(654321);
        check("busy_no_gap", 32'(gif.busy), 32'd1);
        wait_idle(n);

        // Reset in mid-conversion aborts it; no commit may follow.
        pulse(500);
        step(8);
        resetN = 1'b0;
        #1;
        check("abort_busy", 32'(gif.busy), 32'd0);
        check("abort_valid", 32'(gif.digits_valid), 32'd0);
        check("abort_hex", 32'(cur_hex()), 32'(EXP_RST));
        step(2);
        resetN = 1'b1;
        step(40);
        check("abort_idle_busy", 32'(gif.busy), 32'd0);
        check("abort_idle_hex", 32'(cur_hex()), 32'(EXP_RST));

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
